prbs_xnor_checker: RTL and testbench

- Receive-side checker for a serial PRBS stream produced by an XNOR-feedback LFSR generator.
- Self-seeds from the incoming bits and hunts for lock.
- Once locked, free-runs its own LFSR and counts bit errors.
- Sits at the sink end of the link, opposite the XNOR PRBS generator, for BER and loopback test.

---
 rtl/prbs_pkg.sv | 10 +
 rtl/prbs_xnor_lfsr_step.sv | 15 +
 rtl/prbs_xnor_checker.sv | 98 +++++++++
 tb/tb_prbs_xnor_checker.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared FSM states, PRBS7 defaults and the XNOR expected-bit function
package prbs_pkg;
    typedef enum logic [1:0] {SEED, HUNT, LOCKED} prbs_state_t;
    localparam int PRBS_WIDTH = 7;
    localparam int PRBS_TAP_A = 7;
    localparam int PRBS_TAP_B = 6;
    function automatic logic prbs_exp(input logic [63:0] s, input int ta, input int tb);
        return ~(s[6'(ta - 1)] ^ s[6'(tb - 1)]);
    endfunction
endpackage

// File: rtl/prbs_xnor_lfsr_step.sv
// prbs_xnor_lfsr_step: one combinational XNOR LFSR step (expected bit and next state)
module prbs_xnor_lfsr_step import prbs_pkg::*; #(
    parameter int WIDTH = PRBS_WIDTH,
    parameter int TAP_A = PRBS_TAP_A,
    parameter int TAP_B = PRBS_TAP_B
) (
    input  logic [WIDTH-1:0] state,
    input  logic             bit_in,
    input  logic             free_run,
    output logic             exp,
    output logic [WIDTH-1:0] nxt
);
    assign exp = prbs_exp(64'(state), TAP_A, TAP_B);
    assign nxt = {state[WIDTH-2:0], free_run ? exp : bit_in};
endmodule

// File: rtl/prbs_xnor_checker.sv
// prbs_xnor_checker: self-seeding XNOR PRBS checker with lock hunt and error counting; PRBS_CHK_BITCNT_EN adds bit_cnt
module prbs_xnor_checker import prbs_pkg::*; #(
    parameter int WIDTH      = PRBS_WIDTH,
    parameter int TAP_A      = PRBS_TAP_A,
    parameter int TAP_B      = PRBS_TAP_B,
    parameter int LOCK_CNT   = 16,
    parameter int WIN_LEN    = 128,
    parameter int UNLOCK_ERR = 8,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_cnt
`endif
);
    localparam int SW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN_LEN + 1);
    localparam int EW = $clog2(UNLOCK_ERR + 1);

    prbs_state_t fsm, fsm_nxt;
    logic [WIDTH-1:0] state, state_nxt;
    logic [SW-1:0] seed_cnt;
    logic [MW-1:0] match_cnt;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] err_win;
    logic exp, match, mism, chk_err, win_go;

    prbs_xnor_lfsr_step #(.WIDTH(WIDTH), .TAP_A(TAP_A), .TAP_B(TAP_B)) u_step (
        .state(state),
        .bit_in(din),
        .free_run(fsm == LOCKED),
        .exp(exp),
        .nxt(state_nxt)
    );

    // all-ones is the XNOR lockup state and must never count towards lock
    assign match   = (din == exp) && (state != '1);
    assign mism    = din != exp;
    assign chk_err = din_vld && fsm == LOCKED && mism;
    assign win_go  = fsm == LOCKED && fsm_nxt == LOCKED && win_cnt != WW'(WIN_LEN - 1);
    assign locked  = fsm == LOCKED;

    always_comb begin
        fsm_nxt = fsm;
        if (din_vld)
            case (fsm)
                SEED:    fsm_nxt = seed_cnt == SW'(WIDTH - 1) ? HUNT : SEED;
                HUNT:    fsm_nxt = match && match_cnt == MW'(LOCK_CNT - 1) ? LOCKED : HUNT;
                LOCKED:  fsm_nxt = mism && err_win == EW'(UNLOCK_ERR - 1) ? SEED : LOCKED;
                default: fsm_nxt = SEED;
            endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= SEED;
            state     <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            err_win   <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            fsm       <= fsm_nxt;
            err_pulse <= chk_err;
            if (err_clr)
                err_cnt <= '0;
            else if (chk_err && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
            if (din_vld) begin
                state     <= state_nxt;
                seed_cnt  <= (fsm == SEED && fsm_nxt == SEED) ? seed_cnt + 1'b1 : '0;
                match_cnt <= (fsm == HUNT && fsm_nxt == HUNT && match) ? match_cnt + 1'b1 : '0;
                win_cnt   <= win_go ? win_cnt + 1'b1 : '0;
                err_win   <= win_go ? err_win + EW'(mism) : '0;
            end
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    always_ff @(posedge clk) begin
        if (rst || err_clr)
            bit_cnt <= '0;
        else if (din_vld && fsm == LOCKED && bit_cnt != '1)
            bit_cnt <= bit_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_prbs_xnor_checker.sv
// tb_prbs_xnor_checker: directed test-plan scenarios plus randomized traffic against a queue-based reference model
module tb_prbs_xnor_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic din_vld = 1'b0;
    logic err_clr = 1'b0;
    logic locked, err_pulse;
    logic [15:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_cnt;
`endif

    always #5 clk = ~clk;

    prbs_xnor_checker dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_vld(din_vld),
        .err_clr(err_clr),
        .locked(locked),
        .err_pulse(err_pulse),
        .err_cnt(err_cnt)
`ifdef PRBS_CHK_BITCNT_EN
        ,
        .bit_cnt(bit_cnt)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [6:0] gen;
    logic hist[$];
    int m_st, m_seed, m_match, m_win, m_ew, m_err, m_bits;
    logic m_pulse;

    task automatic check(input string tag, input longint got, input longint expv);
        n_chk++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
    endtask

    task automatic model_reset();
        hist = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        m_st = 0; m_seed = 0; m_match = 0; m_win = 0; m_ew = 0; m_err = 0; m_bits = 0;
        m_pulse = 1'b0;
        gen = '0;
    endtask

    // hist holds the last seven bits, oldest first: hist[0] is tap 7, hist[1] is tap 6
    task automatic model_step(input logic v, input logic d, input logic c);
        logic e, all1;
        m_pulse = 1'b0;
        if (v) begin
            e = ~(hist[0] ^ hist[1]);
            all1 = 1'b1;
            foreach (hist[i]) all1 &= hist[i];
            if (m_st == 0) begin
                hist.push_back(d);
                m_seed++;
                if (m_seed == 7) begin m_st = 1; m_seed = 0; m_match = 0; end
            end else if (m_st == 1) begin
                m_match = (d == e && !all1) ? m_match + 1 : 0;
                hist.push_back(d);
                if (m_match == 16) begin m_st = 2; m_win = 0; m_ew = 0; m_match = 0; end
            end else begin
                hist.push_back(e);
                if (m_bits < 32'hFFFF_FFFF) m_bits++;
                m_win++;
                if (d != e) begin
                    m_pulse = 1'b1;
                    if (!c && m_err < 65535) m_err++;
                    m_ew++;
                end
                if (m_ew == 8) begin m_st = 0; m_seed = 0; m_win = 0; m_ew = 0; end
                else if (m_win == 128) begin m_win = 0; m_ew = 0; end
            end
            void'(hist.pop_front());
        end
        if (c) begin m_err = 0; m_bits = 0; end
    endtask

    task automatic step(input logic v, input logic d, input logic c);
        din_vld = v; din = d; err_clr = c;
        model_step(v, d, c);
        @(posedge clk);
        #1;
        check("locked", locked, m_st == 2);
        check("err_pulse", err_pulse, m_pulse);
        check("err_cnt", err_cnt, m_err);
`ifdef PRBS_CHK_BITCNT_EN
        check("bit_cnt", bit_cnt, m_bits);
`endif
        din_vld = 1'b0; err_clr = 1'b0;
    endtask

    task automatic gen_bit(output logic b);
        b = ~(gen[6] ^ gen[5]);
        gen = {gen[5:0], b};
    endtask

    task automatic send(input logic flip, input logic c);
        logic b;
        gen_bit(b);
        step(1'b1, b ^ flip, c);
    endtask

    task automatic do_reset(input logic v);
        rst = 1'b1; din_vld = v; din = 1'($urandom); err_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; din_vld = 1'b0;
        model_reset();
        check("rst_locked", locked, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_cnt", err_cnt, 0);
    endtask

    task automatic wait_lock(input string tag);
        int n;
        n = 0;
        while (!locked && n < 100) begin send(1'b0, 1'b0); n++; end
        check(tag, n, 23);
    endtask

    initial begin
        int lock_at;
        logic seen;
        model_reset();
        do_reset(1'b0);

        lock_at = -1;
        for (int i = 1; i <= 1000; i++) begin
            send(1'b0, 1'b0);
            if (locked && lock_at < 0) lock_at = i;
        end
        check("clean_lock_bit", lock_at, 23);
        check("clean_err_cnt", err_cnt, 0);

        do_reset(1'b0);
        for (int i = 0; i < 300; i++) begin
            send(i == 200, 1'b0);
            if (i == 200) check("single_pulse_hi", err_pulse, 1);
            if (i == 201) check("single_pulse_lo", err_pulse, 0);
        end
        check("single_err_cnt", err_cnt, 1);
        check("single_locked", locked, 1);

        do_reset(1'b0);
        wait_lock("lock_before_burst");
        for (int i = 0; i < 76; i++) begin
            send(i % 10 == 5, 1'b0);
            if (i == 74) check("burst_still_locked", locked, 1);
        end
        check("burst_unlock", locked, 0);
        check("burst_err_cnt", err_cnt, 8);
        wait_lock("relock_bits");

        do_reset(1'b0);
        wait_lock("lock_before_7x2");
        for (int i = 0; i < 256; i++) send((i % 128) % 16 == 3 && (i % 128) < 112, 1'b0);
        check("split_locked", locked, 1);
        check("split_err_cnt", err_cnt, 14);

        do_reset(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, 1'b0);
            seen |= locked;
        end
        check("ones_never_lock", seen, 0);

        do_reset(1'b0);
        wait_lock("lock_before_clr");
        send(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
        check("pre_clr_err_cnt", err_cnt, 1);
        send(1'b1, 1'b1);
        check("clr_pulse", err_pulse, 1);
        check("clr_err_cnt", err_cnt, 0);
        do_reset(1'b1);

        do_reset(1'b0);
        for (int i = 0; i < 4000; i++) begin
            logic v, b;
            v = $urandom_range(0, 3) != 0;
            if (v) begin
                gen_bit(b);
                step(1'b1, b ^ ($urandom_range(0, 59) == 0), $urandom_range(0, 199) == 0);
            end else begin
                step(1'b0, 1'($urandom), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
